register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter: DATA_W, default `WORD_SIZE (32), register and data width.
REQ-002 Parameter: BYPASS, default 1, enables write-to-read forwarding within the same cycle.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: A1D  input  5  read address, port 1 (decode stage rs1).
REQ-006 Port: A2D  input  5  read address, port 2 (decode stage rs2).
REQ-007 Port: RD1D  output  DATA_W  read data, port 1.
REQ-008 Port: RD2D  output  DATA_W  read data, port 2.
REQ-009 Port: RdW  input  5  write address, from the writeback stage.
REQ-010 Port: ResultW  input  DATA_W  write data, from the writeback stage.
REQ-011 Port: RegWriteW  input  1  write enable, from the writeback stage.
REQ-012 Port: DbgA  input  5  debug read address.
REQ-013 Port: DbgD  output  DATA_W  debug read data; never bypassed.
REQ-014 Port: WrCount  output  32  count of effective writes since reset.

Function
REQ-015 Storage SHALL be 32 registers x0..x31, each DATA_W bits.
REQ-016 x0 SHALL always read 0 on every read port; writes to x0 SHALL be discarded.
REQ-017 An effective write SHALL occur when RegWriteW=1 and RdW!=0; register[RdW] SHALL take ResultW at the rising clk edge.
REQ-018 Reads SHALL be combinational: RDnD = register[AnD] with 0 latency from the address.
REQ-019 With BYPASS=1, when an effective write is pending and AnD==RdW, RDnD SHALL equal ResultW in that same cycle.
REQ-020 With BYPASS=0, RDnD SHALL return the stored value; the written value SHALL become visible from the cycle after the edge.
REQ-021 Both read ports SHALL independently hit the same address or the bypass in the same cycle.
REQ-022 DbgD SHALL return the stored register[DbgA], with DbgA=0 returning 0, and SHALL never be forwarded.
REQ-023 WrCount SHALL increment by 1 on each effective write.
REQ-024 WrCount SHALL NOT change on writes to x0 or when RegWriteW=0.
REQ-025 WrCount SHALL wrap from 0xFFFFFFFF to 0 without flagging.
REQ-026 Consecutive-cycle writes to the same register SHALL leave the last value stored (last-writer-wins).

Reset
REQ-027 While rst=1, all 32 registers and WrCount SHALL be 0 immediately (asynchronous), independent of clk.
REQ-028 While rst=1, writes SHALL be ignored.
REQ-029 While rst=1, RD1D, RD2D and DbgD SHALL read 0, including any bypass path.
REQ-030 If rst asserts in the same cycle as a write, the write SHALL be lost.
REQ-031 After rst deasserts, the first write SHALL take effect at the next rising clk edge.

Structure
REQ-032 DATA_W default (`WORD_SIZE) and the register address width (5) SHALL come from the shared constants file; NUM_REGS=32 SHALL be added there.
REQ-033 The block SHALL be self-contained with no sub-module; an optional regfile_bypass sub-module (address compare plus mux) MAY be instantiated once per read port.

Verification
REQ-034 Reset, then read all 32 addresses on A1D/A2D/DbgD -> all read 0x00000000; WrCount=0.
REQ-035 Write x5=0xDEADBEEF, then read A1D=5, A2D=5 next cycle -> both read 0xDEADBEEF; WrCount=1.
REQ-036 RegWriteW=1, RdW=0, ResultW=0x12345678 -> RD1D with A1D=0 reads 0; WrCount unchanged.
REQ-037 BYPASS=1: RdW=7, ResultW=0xA5A5A5A5, RegWriteW=1, A2D=7, same cycle -> RD2D=0xA5A5A5A5 while DbgD(7) shows the old value; with BYPASS=0 -> RD2D shows the old value.
REQ-038 Write x3=1 then x3=2 on back-to-back edges -> x3 reads 2; WrCount +2.
REQ-039 Assert rst between clock edges after writes -> all outputs 0 immediately without a clk edge; force WrCount to 0xFFFFFFFF, then one write -> WrCount=0.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared constants for the register file: word size, register address width and
// register count, plus the helper that decides whether a writeback actually lands.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package register_file_pkg;

  localparam int WORD_SIZE  = `WORD_SIZE;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int COUNT_W    = 32;

  // x0 is hardwired to zero, so a write aimed at it never counts as a real write
  function automatic logic isEffectiveWrite(input logic regWrite,
                                            input logic [REG_ADDR_W-1:0] rdAddr);
    return regWrite && (rdAddr != '0);
  endfunction

endpackage

// File: rtl/register_file_bypass.sv
// Per-read-port forwarding: substitutes the in-flight writeback data for the
// stored value when the addresses match and forwarding is enabled.
module register_file_bypass
  import register_file_pkg::*;
#(
  parameter int DATA_W = `WORD_SIZE,
  parameter int BYPASS = 1
) (
  input  logic [REG_ADDR_W-1:0] rdAddr,
  input  logic [DATA_W-1:0]     storedData,
  input  logic                  wrValid,
  input  logic [REG_ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0]     wrData,
  output logic [DATA_W-1:0]     rdData
);

  logic hit;

  assign hit    = (BYPASS != 0) && wrValid && (rdAddr == wrAddr);
  assign rdData = hit ? wrData : storedData;

endmodule

// File: rtl/register_file.sv
// 32 x DATA_W register file with two forwarded read ports, one unforwarded debug
// read port and a running count of effective writes.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_W = `WORD_SIZE,
  parameter int BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] A1D,
  input  logic [REG_ADDR_W-1:0] A2D,
  output logic [DATA_W-1:0]     RD1D,
  output logic [DATA_W-1:0]     RD2D,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic [DATA_W-1:0]     ResultW,
  input  logic                  RegWriteW,
  input  logic [REG_ADDR_W-1:0] DbgA,
  output logic [DATA_W-1:0]     DbgD,
  output logic [COUNT_W-1:0]    WrCount
);

  logic [DATA_W-1:0]  regs [NUM_REGS];
  logic [COUNT_W-1:0] wrCountQ;
  logic               wrEffective;
  logic               fwdValid;
  logic [DATA_W-1:0]  stored1;
  logic [DATA_W-1:0]  stored2;

  assign wrEffective = isEffectiveWrite(RegWriteW, RdW);

  // Forwarding must stay silent during reset so the read ports show all-zero state
  assign fwdValid = wrEffective && !rst;

  // x0 is never written, so it stays at its reset value of zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      wrCountQ <= '0;
    end else if (wrEffective) begin
      regs[RdW] <= ResultW;
      wrCountQ  <= wrCountQ + COUNT_W'(1);
    end
  end

  assign stored1 = (A1D == '0) ? '0 : regs[A1D];
  assign stored2 = (A2D == '0) ? '0 : regs[A2D];

  register_file_bypass #(
    .DATA_W (DATA_W),
    .BYPASS (BYPASS)
  ) bypass1 (
    .rdAddr     (A1D),
    .storedData (stored1),
    .wrValid    (fwdValid),
    .wrAddr     (RdW),
    .wrData     (ResultW),
    .rdData     (RD1D)
  );

  register_file_bypass #(
    .DATA_W (DATA_W),
    .BYPASS (BYPASS)
  ) bypass2 (
    .rdAddr     (A2D),
    .storedData (stored2),
    .wrValid    (fwdValid),
    .wrAddr     (RdW),
    .wrData     (ResultW),
    .rdData     (RD2D)
  );

  assign DbgD    = (DbgA == '0) ? '0 : regs[DbgA];
  assign WrCount = wrCountQ;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench: a forwarding and a non-forwarding register file share
// stimulus and are compared against an array-based model of the register state.
`timescale 1ns/1ps

module tb_register_file;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  A1D = '0;
  logic [4:0]  A2D = '0;
  logic [4:0]  RdW = '0;
  logic [31:0] ResultW = '0;
  logic        RegWriteW = 1'b0;
  logic [4:0]  DbgA = '0;

  logic [31:0] rd1Byp, rd2Byp, dbgByp, cntByp;
  logic [31:0] rd1Raw, rd2Raw, dbgRaw, cntRaw;

  logic [31:0] model [32];
  logic [31:0] modelCount = '0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  register_file #(.DATA_W(32), .BYPASS(1)) dutByp (
    .clk(clk), .rst(rst), .A1D(A1D), .A2D(A2D), .RD1D(rd1Byp), .RD2D(rd2Byp),
    .RdW(RdW), .ResultW(ResultW), .RegWriteW(RegWriteW), .DbgA(DbgA),
    .DbgD(dbgByp), .WrCount(cntByp)
  );

  register_file #(.DATA_W(32), .BYPASS(0)) dutRaw (
    .clk(clk), .rst(rst), .A1D(A1D), .A2D(A2D), .RD1D(rd1Raw), .RD2D(rd2Raw),
    .RdW(RdW), .ResultW(ResultW), .RegWriteW(RegWriteW), .DbgA(DbgA),
    .DbgD(dbgRaw), .WrCount(cntRaw)
  );

  // What a read port should show given the model state and the pending writeback
  function automatic logic [31:0] expRead(input logic [4:0] addr, input bit fwd);
    if (rst || addr == 5'd0) return 32'h0;
    if (fwd && RegWriteW && RdW != 5'd0 && RdW == addr) return ResultW;
    return model[addr];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, " byp.RD1D"}, rd1Byp, expRead(A1D, 1'b1));
    checkOutput({tag, " byp.RD2D"}, rd2Byp, expRead(A2D, 1'b1));
    checkOutput({tag, " byp.DbgD"}, dbgByp, expRead(DbgA, 1'b0));
    checkOutput({tag, " byp.WrCount"}, cntByp, modelCount);
    checkOutput({tag, " raw.RD1D"}, rd1Raw, expRead(A1D, 1'b0));
    checkOutput({tag, " raw.RD2D"}, rd2Raw, expRead(A2D, 1'b0));
    checkOutput({tag, " raw.DbgD"}, dbgRaw, expRead(DbgA, 1'b0));
    checkOutput({tag, " raw.WrCount"}, cntRaw, modelCount);
  endtask

  // Advance one clock: commit the pending write into the model, return at the negedge
  task automatic tick();
    @(posedge clk);
    if (!rst && RegWriteW && RdW != 5'd0) begin
      model[RdW] = ResultW;
      modelCount = modelCount + 32'd1;
    end
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] rd, input logic [31:0] data,
                               input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] dbg);
    RegWriteW = we;
    RdW       = rd;
    ResultW   = data;
    A1D       = a1;
    A2D       = a2;
    DbgA      = dbg;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    // Reset: every address reads zero on all three ports
    #2 rst = 1'b1;
    #1;
    for (int a = 0; a < 32; a++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 5'(a), 5'(a), 5'(a));
      checkAll("reset-sweep");
    end
    @(negedge clk);
    rst = 1'b0;

    // Write x5 then read it on both ports the next cycle
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);
    checkAll("x5-read");
    checkOutput("x5 RD1D const", rd1Byp, 32'hDEADBEEF);
    checkOutput("x5 WrCount const", cntByp, 32'd1);

    // Writes to x0 are discarded and not counted
    applyStimulus(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd5, 5'd0);
    checkAll("x0-write-pending");
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    checkAll("x0-write-after");
    checkOutput("x0 WrCount const", cntByp, 32'd1);

    // Same-cycle forwarding versus stored value
    applyStimulus(1'b1, 5'd7, 32'hA5A5A5A5, 5'd5, 5'd7, 5'd7);
    checkAll("bypass-x7");
    checkOutput("bypass RD2D fwd const", rd2Byp, 32'hA5A5A5A5);
    checkOutput("bypass RD2D raw const", rd2Raw, 32'h0);
    checkOutput("bypass DbgD const", dbgByp, 32'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd7);
    checkAll("x7-after");

    // Back-to-back writes to x3: last writer wins
    applyStimulus(1'b1, 5'd3, 32'd1, 5'd3, 5'd3, 5'd3);
    tick();
    applyStimulus(1'b1, 5'd3, 32'd2, 5'd3, 5'd3, 5'd3);
    checkAll("x3-second-pending");
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 5'd3);
    checkAll("x3-final");
    checkOutput("x3 value const", rd1Raw, 32'd2);
    checkOutput("x3 WrCount const", cntRaw, 32'd4);

    // Randomized traffic, biased toward a few registers to exercise forwarding
    for (int n = 0; n < 400; n++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      applyStimulus(1'($urandom), rd, $urandom,
                    ($urandom_range(0, 2) == 0) ? rd : 5'($urandom),
                    ($urandom_range(0, 2) == 0) ? rd : 5'($urandom),
                    ($urandom_range(0, 1) == 0) ? rd : 5'($urandom));
      checkAll("random");
      tick();
    end

    // Asynchronous reset between edges with a write pending
    applyStimulus(1'b1, 5'd5, 32'hCAFEF00D, 5'd5, 5'd5, 5'd5);
    #2 rst = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    modelCount = 32'h0;
    #1;
    checkAll("async-reset");
    checkOutput("async-reset RD1D const", rd1Byp, 32'h0);
    tick();
    checkAll("reset-held-write");
    rst = 1'b0;
    #1;
    checkAll("reset-released");
    tick();
    checkAll("first-write-after-reset");
    checkOutput("first write RD1D const", rd1Raw, 32'hCAFEF00D);

    // WrCount wrap: preload all-ones, one effective write brings it to zero
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    force dutByp.wrCountQ = 32'hFFFFFFFF;
    force dutRaw.wrCountQ = 32'hFFFFFFFF;
    #1;
    release dutByp.wrCountQ;
    release dutRaw.wrCountQ;
    modelCount = 32'hFFFFFFFF;
    #1;
    checkAll("wrap-preload");
    applyStimulus(1'b1, 5'd9, 32'h0BADBEEF, 5'd9, 5'd1, 5'd9);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 5'd9);
    checkAll("wrap-after");
    checkOutput("wrap WrCount const", cntByp, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
